hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum consecutive MEM_WAIT cycles before error.
REQ-002 Parameter CNT_W, default 16: width of performance counters.
REQ-003 clk  in  1  single clock, rising-edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID.
REQ-006 uses_rs1_ID, uses_rs2_ID  in  1 each  ID instruction reads rs1/rs2.
REQ-007 rd_EX  in  5  destination of the instruction in EX.
REQ-008 MemRead_EX  in  1  EX instruction is a load.
REQ-009 branch_taken_EX  in  1  branch/jump resolved taken in EX.
REQ-010 mem_req_MEM, mem_ready_MEM  in  1 each  data-memory request and ready from MEM.
REQ-011 PC_Write, IF_ID_Write  out  1 each  PC and IF/ID register enables.
REQ-012 IF_ID_Flush, ID_EX_Flush  out  1 each  insert bubble into IF/ID and ID/EX.
REQ-013 pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
REQ-014 MEM_WB_Bubble  out  1  clear RegWrite/MemToReg entering MEM/WB.
REQ-015 state_o  out  2  current FSM state.
REQ-016 timeout_err  out  1  sticky memory-timeout flag.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 FSM states SHALL be RUN=0, MEM_WAIT=1, ERR=2; encoding 3 is illegal and SHALL return to RUN on the next edge.
REQ-019 Control outputs SHALL be combinational from the current state and current inputs; counters, state and timeout_err SHALL be registered.
REQ-020 Load-use hazard SHALL be MemRead_EX && rd_EX!=0 && ((uses_rs1_ID && rs1_ID==rd_EX) || (uses_rs2_ID && rs2_ID==rd_EX)).
REQ-021 RUN, default: PC_Write=1, IF_ID_Write=1; all other control outputs 0.
REQ-022 RUN with mem_req_MEM && !mem_ready_MEM: PC_Write=0, IF_ID_Write=0, pipe_freeze=1, MEM_WB_Bubble=1; next state MEM_WAIT; this outranks branch and load-use.
REQ-023 RUN with branch_taken_EX (no memory wait): IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1; outranks load-use.
REQ-024 RUN with load-use only: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; one-cycle stall, state stays RUN.
REQ-025 MEM_WAIT: outputs as REQ-022; on mem_ready_MEM=1 return to RUN next edge, with that cycle still frozen; branch and load-use SHALL be ignored while in MEM_WAIT.
REQ-026 A wait-cycle counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle; reaching MEM_TIMEOUT without ready SHALL set timeout_err and enter ERR.
REQ-027 ERR: PC_Write=0, IF_ID_Write=0, pipe_freeze=1, MEM_WB_Bubble=1; it SHALL persist until rst.
REQ-028 stall_cnt SHALL increment on every cycle with PC_Write=0; flush_cnt SHALL increment on every REQ-023 cycle; both SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-029 While rst=1: state=RUN, wait counter=0, timeout_err=0, stall_cnt=0, flush_cnt=0.
REQ-030 Reset asserted mid-MEM_WAIT or in ERR SHALL force RUN immediately; outputs then follow REQ-021 to REQ-024.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the state enumeration and the REG_ZERO=5'd0 constant.
REQ-032 One sub-module sat_counter (parameter W, inputs clk, rst, inc; output count) SHALL implement both event counters.

Verification
REQ-033 Load-use: MemRead_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 -> one cycle with PC_Write=0, ID_EX_Flush=1; stall_cnt=1.
REQ-034 rd_EX=0 with a load and matching rs1_ID=0 -> no stall.
REQ-035 branch_taken_EX with load-use present in the same cycle -> IF_ID_Flush=ID_EX_Flush=1, PC_Write=1; flush_cnt=1.
REQ-036 mem_req_MEM=1 and ready low for 3 cycles, with branch_taken_EX=1 throughout -> 4 frozen cycles, then RUN and branch flush; stall_cnt=4.
REQ-037 MEM_TIMEOUT=4 and ready never asserts -> ERR after 4 MEM_WAIT cycles, timeout_err=1; asynchronous rst then returns RUN with counters 0.
REQ-038 CNT_W=2 and 5 load-use stalls -> stall_cnt holds at 3.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline-control definitions: hazard FSM state encoding and the
// architectural zero register index.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hcu_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : riscv_pkg

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// data-memory wait freezing with a timeout that parks the pipe in ERR.
module hazard_control_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             branch_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_ready_MEM,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             pipe_freeze,
    output logic             MEM_WB_Bubble,
    output logic [1:0]       state_o,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hcu_state_t        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout_err;

    logic w_load_use;
    logic w_mem_stall;
    logic w_flush_evt;

    assign w_load_use = MemRead_EX && (rd_EX != REG_ZERO) &&
                        ((uses_rs1_ID && (rs1_ID == rd_EX)) ||
                         (uses_rs2_ID && (rs2_ID == rd_EX)));
    assign w_mem_stall = mem_req_MEM && !mem_ready_MEM;

    // Priority in RUN: memory wait, then taken branch, then load-use.
    always_comb begin
        PC_Write      = 1'b0;
        IF_ID_Write   = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Flush   = 1'b0;
        pipe_freeze   = 1'b0;
        MEM_WB_Bubble = 1'b0;
        w_flush_evt   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    pipe_freeze   = 1'b1;
                    MEM_WB_Bubble = 1'b1;
                end else if (branch_taken_EX) begin
                    PC_Write    = 1'b1;
                    IF_ID_Write = 1'b1;
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    w_flush_evt = 1'b1;
                end else if (w_load_use) begin
                    ID_EX_Flush = 1'b1;
                end else begin
                    PC_Write    = 1'b1;
                    IF_ID_Write = 1'b1;
                end
            end
            default: begin
                pipe_freeze   = 1'b1;
                MEM_WB_Bubble = 1'b1;
            end
        endcase
    end

    // The ready cycle in MEM_WAIT is still frozen; RUN resumes on the next edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_mem_stall) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_MEM) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state       <= ERR;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign state_o     = r_state;
    assign timeout_err = r_timeout_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!PC_Write),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_evt),
        .count (flush_cnt)
    );

endmodule : hazard_control_unit

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a default-parameter instance and a
// small instance (MEM_TIMEOUT=4, CNT_W=2) share one stimulus stream.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_ID, rs2_ID, rd_EX;
    logic       uses_rs1_ID, uses_rs2_ID, MemRead_EX, branch_taken_EX;
    logic       mem_req_MEM, mem_ready_MEM;

    logic        pc_w, ifid_w, ifid_f, idex_f, frz, bub, terr;
    logic [1:0]  st;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_frz, s_bub, s_terr;
    logic [1:0]  s_st;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    logic [5:0] ctrl, s_ctrl;
    assign ctrl   = {pc_w, ifid_w, ifid_f, idex_f, frz, bub};
    assign s_ctrl = {s_pc_w, s_ifid_w, s_ifid_f, s_idex_f, s_frz, s_bub};

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze, MEM_WB_Bubble}
    localparam logic [5:0] C_RUN = 6'b110000;
    localparam logic [5:0] C_LU  = 6'b000100;
    localparam logic [5:0] C_BR  = 6'b111100;
    localparam logic [5:0] C_FRZ = 6'b000011;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit u_dut (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
        .PC_Write(pc_w), .IF_ID_Write(ifid_w),
        .IF_ID_Flush(ifid_f), .ID_EX_Flush(idex_f),
        .pipe_freeze(frz), .MEM_WB_Bubble(bub),
        .state_o(st), .timeout_err(terr),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
        .rd_EX(rd_EX), .MemRead_EX(MemRead_EX),
        .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
        .PC_Write(s_pc_w), .IF_ID_Write(s_ifid_w),
        .IF_ID_Flush(s_ifid_f), .ID_EX_Flush(s_idex_f),
        .pipe_freeze(s_frz), .MEM_WB_Bubble(s_bub),
        .state_o(s_st), .timeout_err(s_terr),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
        uses_rs1_ID = 1'b0; uses_rs2_ID = 1'b0;
        MemRead_EX = 1'b0; branch_taken_EX = 1'b0;
        mem_req_MEM = 1'b0; mem_ready_MEM = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        MemRead_EX = 1'b1; rd_EX = r; rs1_ID = r; uses_rs1_ID = 1'b1;
    endtask

    initial begin
        // Reset state
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", st, 0);
        check("rst_terr", terr, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_flush", flush_cnt, 0);
        check("rst_ctrl", ctrl, C_RUN);
        @(negedge clk); rst = 1'b0;

        // Load-use via rs1
        @(negedge clk); load_use(5'd5); #1;
        check("lu_ctrl", ctrl, C_LU);
        @(negedge clk); idle(); #1;
        check("lu_after_ctrl", ctrl, C_RUN);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_state", st, 0);

        // Load to x0 never stalls
        @(negedge clk); load_use(5'd0); #1;
        check("x0_ctrl", ctrl, C_RUN);

        // Load-use via rs2 only
        @(negedge clk); idle();
        MemRead_EX = 1'b1; rd_EX = 5'd7; rs2_ID = 5'd7; uses_rs2_ID = 1'b1; rs1_ID = 5'd7;
        #1;
        check("rs2_ctrl", ctrl, C_LU);
        check("x0_stall_cnt", stall_cnt, 1);
        @(negedge clk); uses_rs2_ID = 1'b0; #1;
        check("unused_ctrl", ctrl, C_RUN);
        check("rs2_stall_cnt", stall_cnt, 2);

        // Branch outranks load-use
        @(negedge clk); idle(); load_use(5'd5); branch_taken_EX = 1'b1; #1;
        check("br_ctrl", ctrl, C_BR);
        @(negedge clk); idle(); #1;
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);

        // Asynchronous reset clears counters immediately
        @(negedge clk); rst = 1'b1; #1;
        check("arst_stall", stall_cnt, 0);
        check("arst_flush", flush_cnt, 0);
        @(negedge clk); rst = 1'b0;

        // Memory wait with branch held high throughout
        @(negedge clk); mem_req_MEM = 1'b1; mem_ready_MEM = 1'b0; branch_taken_EX = 1'b1; #1;
        check("mw0_ctrl", ctrl, C_FRZ);
        check("mw0_state", st, 0);
        @(negedge clk); #1;
        check("mw1_ctrl", ctrl, C_FRZ);
        check("mw1_state", st, 1);
        @(negedge clk); #1;
        check("mw2_ctrl", ctrl, C_FRZ);
        check("mw2_state", st, 1);
        @(negedge clk); mem_ready_MEM = 1'b1; #1;
        check("mw3_ctrl", ctrl, C_FRZ);
        check("mw3_state", st, 1);
        @(negedge clk); #1;
        check("mw_exit_state", st, 0);
        check("mw_exit_ctrl", ctrl, C_BR);
        check("mw_stall_cnt", stall_cnt, 4);
        check("mw_flush_pre", flush_cnt, 0);
        @(negedge clk); idle(); #1;
        check("mw_flush_cnt", flush_cnt, 1);
        check("mw_stall_hold", stall_cnt, 4);

        // Five load-use stalls saturate the 2-bit counter
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); load_use(5'd3);
        repeat (5) @(negedge clk);
        idle(); #1;
        check("sat_small_stall", s_stall_cnt, 3);
        check("sat_big_stall", stall_cnt, 5);
        check("sat_small_ctrl", s_ctrl, C_RUN);

        // Memory timeout on the small instance
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); mem_req_MEM = 1'b1; mem_ready_MEM = 1'b0; #1;
        check("to_start_state", s_st, 0);
        repeat (4) @(negedge clk);
        #1;
        check("to_wait4_state", s_st, 1);
        check("to_wait4_terr", s_terr, 0);
        @(negedge clk); #1;
        check("to_err_state", s_st, 2);
        check("to_err_terr", s_terr, 1);
        check("to_err_ctrl", s_ctrl, C_FRZ);
        check("to_big_state", st, 1);
        @(negedge clk); idle();
        @(negedge clk); #1;
        check("err_persist_state", s_st, 2);
        check("err_persist_terr", s_terr, 1);
        #2 rst = 1'b1;
        #1;
        check("err_rst_state", s_st, 0);
        check("err_rst_terr", s_terr, 0);
        check("err_rst_stall", s_stall_cnt, 0);
        check("err_rst_flush", s_flush_cnt, 0);
        check("err_rst_ctrl", s_ctrl, C_RUN);
        check("err_rst_big_state", st, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); load_use(5'd9); #1;
        check("post_err_lu_ctrl", s_ctrl, C_LU);
        @(negedge clk); idle(); #1;
        check("post_err_stall", s_stall_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_control_unit
